// File: rtl/ysyx_22041211_axil_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ysyx_22041211_axil_dmem                                         |
// | Desc   : AXI-lite data-memory slave backed by a word-organised array,    |
// |          programmable read/write latency, one outstanding read and one   |
// |          outstanding write, right-justified read data.                   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module ysyx_22041211_axil_dmem #(
  parameter int                  DATA_LEN    = 32,
  parameter int                  ADDR_LEN    = 32,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                  DEPTH_WORDS = 4096,
  parameter int                  RD_LAT      = 2,
  parameter int                  WR_LAT      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  input  logic [ADDR_LEN-1:0] addr_w_addr_i,
  input  logic                addr_w_valid_i,
  output logic                addr_w_ready_o,
  input  logic [DATA_LEN-1:0] w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          bkwd_resp_o,
  output logic                bkwd_valid_o,
  input  logic                bkwd_ready_i
);

  localparam int                  IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_LEN-1:0] SPAN    = ADDR_LEN'(4 * DEPTH_WORDS);
  localparam int                  MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int                  CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0]    RD_CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]    WR_CNT_INIT = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_BUSY = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_BUSY = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_LEN-1:0] mem_q [DEPTH_WORDS];

  // Read channel state
  logic [1:0]          r_state_q, r_state_d;
  logic [CNT_W-1:0]    r_cnt_q, r_cnt_d;
  logic [ADDR_LEN-1:0] ar_addr_q, ar_addr_d;
  logic [DATA_LEN-1:0] r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;

  // Write channel state
  logic [1:0]          w_state_q, w_state_d;
  logic [CNT_W-1:0]    w_cnt_q, w_cnt_d;
  logic [ADDR_LEN-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                aw_lat_q, aw_lat_d;
  logic                w_lat_q, w_lat_d;
  logic [1:0]          b_resp_q, b_resp_d;
  logic                w_commit;

  // Address decode on the latched addresses; the offset's top bits feed the
  // range compare, so a wrap below BASE_ADDR also reads as out of range.
  logic [ADDR_LEN-1:0] ar_off, aw_off;
  logic                ar_hit, aw_hit;
  logic [IDX_W-1:0]    ar_idx, aw_idx;
  logic                unused_aw_lsb;

  assign ar_off = ar_addr_q - BASE_ADDR;
  assign aw_off = aw_addr_q - BASE_ADDR;
  assign ar_hit = (ar_addr_q >= BASE_ADDR) && (ar_off < SPAN);
  assign aw_hit = (aw_addr_q >= BASE_ADDR) && (aw_off < SPAN);
  assign ar_idx = ar_off[IDX_W+1:2];
  assign aw_idx = aw_off[IDX_W+1:2];
  // Writes are lane-aligned, so the byte offset of the write address is moot.
  assign unused_aw_lsb = ^aw_off[1:0];

  logic aw_fire, wd_fire, aw_have, wd_have;
  assign aw_fire = (w_state_q == W_IDLE) && !aw_lat_q && addr_w_valid_i;
  assign wd_fire = (w_state_q == W_IDLE) && !w_lat_q && w_valid_i;
  assign aw_have = aw_lat_q || aw_fire;
  assign wd_have = w_lat_q || wd_fire;

  // Outputs are forced quiet while reset is held.
  assign addr_r_ready_o = !rst && (r_state_q == R_IDLE);
  assign r_valid_o      = !rst && (r_state_q == R_RESP);
  assign r_data_o       = rst ? '0 : r_data_q;
  assign r_resp_o       = rst ? 2'b00 : r_resp_q;
  assign addr_w_ready_o = !rst && (w_state_q == W_IDLE) && !aw_lat_q;
  assign w_ready_o      = !rst && (w_state_q == W_IDLE) && !w_lat_q;
  assign bkwd_valid_o   = !rst && (w_state_q == W_RESP);
  assign bkwd_resp_o    = rst ? 2'b00 : b_resp_q;

  // Read FSM next state: accept AR, count down latency, sample and hold data.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: begin
        if (addr_r_valid_i) begin
          ar_addr_d = addr_r_addr_i;
          r_cnt_d   = RD_CNT_INIT;
          r_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        if (r_cnt_q == '0) begin
          if (ar_hit) begin
            r_data_d = mem_q[ar_idx] >> {ar_off[1:0], 3'b000};
            r_resp_d = RESP_OKAY;
          end else begin
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
          end
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - CNT_ONE;
        end
      end
      R_RESP: begin
        if (r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      ar_addr_q <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Write FSM next state: latch AW and W independently, capture once both
  // are present, count down latency, commit, then hold the response.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    b_resp_d  = b_resp_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_addr_d = addr_w_addr_i;
          aw_lat_d  = 1'b1;
        end
        if (wd_fire) begin
          wdata_d = w_data_i;
          wstrb_d = w_strb_i;
          w_lat_d = 1'b1;
        end
        if (aw_have && wd_have) begin
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          w_cnt_d   = WR_CNT_INIT;
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (w_cnt_q == '0) begin
          w_commit  = 1'b1;
          b_resp_d  = aw_hit ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - CNT_ONE;
        end
      end
      W_RESP: begin
        if (bkwd_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Array byte-lane commit; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && aw_hit) begin
      for (int k = 0; k < DATA_LEN / 8; k++) begin
        if (wstrb_q[k]) mem_q[aw_idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041211_axil_dmem.md
Name: ysyx_22041211_axil_dmem

Overview:
- AXI-lite data-memory slave sitting directly downstream of the LSU's AXI ports; consumes its AR/R/AW/W/B traffic.
- Backs a word-organised SRAM array and responds after programmable read and write latencies, with one outstanding read and one outstanding write.
- Read data is returned right-justified by byte offset so LSU byte/half loads find their data in the low bits.
- Lets the LSU handshake FSM be exercised with multi-cycle slaves in simulation and on the NPC top.

Parameters:
- DATA_LEN, 32, data bus width; only 32 is supported.
- ADDR_LEN, 32, address width.
- BASE_ADDR, 32'h8000_0000, first byte address mapped to the array.
- DEPTH_WORDS, 4096, array depth in 32-bit words; must be a power of two.
- RD_LAT, 2, cycles from AR handshake to r_valid_o assertion; must be ≥1.
- WR_LAT, 2, cycles from write capture to bkwd_valid_o assertion; must be ≥1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- addr_r_addr_i  in  ADDR_LEN  read address.
- addr_r_valid_i  in  1  read address valid.
- addr_r_ready_o  out  1  slave can accept a read address.
- r_data_o  out  DATA_LEN  read data, shifted right by 8*addr[1:0], zero-filled.
- r_resp_o  out  2  2'b00 OKAY, 2'b10 SLVERR.
- r_valid_o  out  1  read data valid.
- r_ready_i  in  1  master accepts read data.
- addr_w_addr_i  in  ADDR_LEN  write address.
- addr_w_valid_i  in  1  write address valid.
- addr_w_ready_o  out  1  slave can accept a write address.
- w_data_i  in  DATA_LEN  write data, lane-aligned.
- w_strb_i  in  4  byte enables; bit k enables lane k (bits 8k+7:8k).
- w_valid_i  in  1  write data valid.
- w_ready_o  out  1  slave can accept write data.
- bkwd_resp_o  out  2  write response, same encoding as r_resp_o.
- bkwd_valid_o  out  1  write response valid.
- bkwd_ready_i  in  1  master accepts the write response.

Behaviour:
- Reset (rst=1 at posedge): read FSM→R_IDLE; write FSM→W_IDLE; AW and W latched flags cleared; counters 0.
  - While rst is high, all readies and valids are 0; r_data_o, r_resp_o and bkwd_resp_o are 0.
  - Array contents are not reset.
  - Reset mid-operation drops any pending transaction; a write that has not yet committed never modifies the array.
- Address decode: in range iff BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH_WORDS; word index = (addr−BASE_ADDR)>>2.
- Read FSM: R_IDLE → R_BUSY → R_RESP.
  - R_IDLE: addr_r_ready_o=1. On arvalid&arready at edge T, latch the address, load counter=RD_LAT−1, go to R_BUSY.
  - R_BUSY: decrement each cycle. When the counter is 0, sample the array, go to R_RESP. r_valid_o rises at edge T+RD_LAT.
  - R_RESP: r_valid_o=1; r_data_o and r_resp_o are held stable until r_valid_o&r_ready_i, then return to R_IDLE. addr_r_ready_o is 1 in the cycle after the R handshake.
  - Out-of-range read: r_resp_o=2'b10, r_data_o=0, same latency.
- Write FSM: W_IDLE → W_BUSY → W_RESP.
  - W_IDLE: addr_w_ready_o = ~aw_latched; w_ready_o = ~w_latched. AW and W may arrive in the same cycle or in either order; each is latched independently.
  - The write is captured at edge T, when both latches are satisfied (including both arriving at T). Then load counter=WR_LAT−1 and go to W_BUSY. Both readies are 0 outside W_IDLE.
  - W_BUSY: when the counter reaches 0, commit the byte lanes selected by strb to the array, go to W_RESP. bkwd_valid_o rises at edge T+WR_LAT.
  - W_RESP: bkwd_valid_o held until bkwd_ready_i, then W_IDLE with latches cleared.
  - Out-of-range write: no array change, bkwd_resp_o=2'b10.
  - strb=4'b0000 in range: no change, OKAY.
- The read and write channels are fully independent and may be busy simultaneously.
- A read sample and a write commit to the same word on the same edge: the read returns the pre-write data.
- Valid outputs never drop before their handshake. Inputs arriving while the slave is busy are ignored (ready=0).

Test Plan:
- Reset, then AR 0x8000_0010 with word=0x1122_3344 preloaded, r_ready_i=1, RD_LAT=2 → r_valid_o rises 2 cycles after the AR handshake, r_data_o=0x1122_3344, r_resp_o=00; addr_r_ready_o=1 the next cycle.
- AR 0x8000_0013 on the same word → r_data_o=0x0000_0011. Hold r_ready_i=0 for 5 cycles → r_valid_o and r_data_o stay stable throughout.
- W (data 0xAABB_CCDD, strb 4'b0110) one cycle before AW 0x8000_0010 → w_ready_o drops after the W handshake. bkwd_valid_o arrives WR_LAT cycles after AW. A following read returns 0x11BB_CC44.
- AR 0x0000_0000 and AW 0x9000_0000 issued together → both respond with SLVERR 2'b10, r_data_o=0, array unchanged.
- Write and read of the same word committing and sampling on the same edge → the read returns the old value; the next read returns the new value.
- rst asserted while in W_BUSY → all valids and readies are 0 on the next cycle, the targeted word is unchanged, and a fresh AR succeeds after rst deasserts.
